// File: rtl/ctr_pipe.sv
// ctr_pipe: decode-stage control unit. It decodes the opcode into an EX-stage
// control vector, detects load-use hazards, squashes on a taken branch,
// holds issue while the floating unit is occupied, and halts on STOP.
module ctr_pipe #(
    parameter int unsigned OP_WIDTH = 4,
    parameter int unsigned RA_WIDTH = 4,
    parameter int unsigned CV_WIDTH = 12,
    parameter int unsigned FP_LAT   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [OP_WIDTH-1:0] opcode_i,
    input  logic [RA_WIDTH-1:0] rs_i,
    input  logic [RA_WIDTH-1:0] rt_i,
    input  logic [RA_WIDTH-1:0] rd_i,
    input  logic                branch_taken_i,
    output logic                ex_valid_o,
    output logic [CV_WIDTH-1:0] ex_cv_o,
    output logic [RA_WIDTH-1:0] ex_rd_o,
    output logic                r_type_o,
    output logic                stall_o,
    output logic                flush_o,
    output logic                halt_o,
    output logic                fp_busy_o
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CV_MEMREAD = 7;
    localparam int unsigned CV_FLOAT   = 1;
    localparam int unsigned CV_STOP    = 0;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FP_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(4'h0);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(4'h1);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(4'h2);
    localparam logic [OP_WIDTH-1:0] OP_MOV   = OP_WIDTH'(4'h3);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(4'h4);
    localparam logic [OP_WIDTH-1:0] OP_JMPZ  = OP_WIDTH'(4'h5);
    localparam logic [OP_WIDTH-1:0] OP_STOP  = OP_WIDTH'(4'h7);
    localparam logic [OP_WIDTH-1:0] OP_ADDF  = OP_WIDTH'(4'h8);
    localparam logic [OP_WIDTH-1:0] OP_MULTF = OP_WIDTH'(4'h9);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(4'hA);
    localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(4'hF);

    // Bit order: {RegWrite,ALUop[1:0],Branch,MemRead,RegDst,MemWrite,Jump,MemToReg,Mov,Floating,Stop}
    function automatic logic [CV_WIDTH-1:0] decode(input logic [OP_WIDTH-1:0] op);
        logic [11:0] cv;
        case (op)
            OP_LW:    cv = 12'b100011001000;
            OP_SW:    cv = 12'b000000100000;
            OP_ADD:   cv = 12'b100000000000;
            OP_MOV:   cv = 12'b100001000100;
            OP_SUB:   cv = 12'b101000000000;
            OP_JMPZ:  cv = 12'b000100000000;
            OP_STOP:  cv = 12'b000000000001;
            OP_ADDF:  cv = 12'b100000000010;
            OP_MULTF: cv = 12'b100000000010;
            OP_SLT:   cv = 12'b110000000000;
            default:  cv = 12'b000000000000;
        endcase
        return CV_WIDTH'(cv);
    endfunction

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ex_valid;
    logic [CV_WIDTH-1:0] r_ex_cv;
    logic [RA_WIDTH-1:0] r_ex_rd;
    logic                r_halt;
    logic                r_fp_busy;

    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_valid_nxt;
    logic [CV_WIDTH-1:0] w_cv_nxt;
    logic [RA_WIDTH-1:0] w_rd_nxt;
    logic                w_halt_nxt;
    logic                w_fp_busy_nxt;
    logic [CV_WIDTH-1:0] w_cv_dec;
    logic                w_r_type;
    logic                w_hazard;
    logic                w_issue;
    logic                w_stall;

    // Decode of the instruction currently in IF/ID.
    always_comb begin
        w_cv_dec = decode(opcode_i);
        w_r_type = (opcode_i == OP_ADD)  || (opcode_i == OP_SUB)  ||
                   (opcode_i == OP_MULTF) || (opcode_i == OP_NOP) ||
                   (opcode_i == OP_STOP) || (opcode_i == OP_JMPZ) ||
                   (opcode_i == OP_SLT);
        w_hazard = valid_i && r_ex_valid && r_ex_cv[CV_MEMREAD] &&
                   ((r_ex_rd == rs_i) ||
                    ((r_ex_rd == rt_i) && (w_r_type || (opcode_i == OP_SW))));
        w_issue  = (r_state == ST_RUN) && valid_i && !branch_taken_i && !w_hazard;
    end

    // Next-state and next-output logic; default is a bubble that keeps ex_rd.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = 1'b0;
        w_cv_nxt      = '0;
        w_rd_nxt      = r_ex_rd;
        w_halt_nxt    = r_halt;
        w_fp_busy_nxt = r_fp_busy;
        w_stall       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hazard && !branch_taken_i;
                if (w_issue) begin
                    w_valid_nxt = 1'b1;
                    w_cv_nxt    = w_cv_dec;
                    w_rd_nxt    = rd_i;
                    if (w_cv_dec[CV_FLOAT] && (FP_LAT > 1)) begin
                        w_state_nxt   = ST_FP_WAIT;
                        w_cnt_nxt     = CNT_W'(FP_LAT - 1);
                        w_fp_busy_nxt = 1'b1;
                    end else if (w_cv_dec[CV_STOP]) begin
                        w_state_nxt = ST_HALT;
                        w_halt_nxt  = 1'b1;
                    end
                end
            end
            ST_FP_WAIT: begin
                w_stall   = !branch_taken_i;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt   = ST_RUN;
                    w_fp_busy_nxt = 1'b0;
                end
            end
            ST_HALT: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_ex_valid <= 1'b0;
            r_ex_cv    <= '0;
            r_ex_rd    <= '0;
            r_halt     <= 1'b0;
            r_fp_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ex_valid <= w_valid_nxt;
            r_ex_cv    <= w_cv_nxt;
            r_ex_rd    <= w_rd_nxt;
            r_halt     <= w_halt_nxt;
            r_fp_busy  <= w_fp_busy_nxt;
        end
    end

    // Output drive; stall is forced low while reset is held.
    always_comb begin
        ex_valid_o = r_ex_valid;
        ex_cv_o    = r_ex_cv;
        ex_rd_o    = r_ex_rd;
        halt_o     = r_halt;
        fp_busy_o  = r_fp_busy;
        r_type_o   = w_r_type;
        flush_o    = branch_taken_i;
        stall_o    = rst_n && w_stall;
    end

endmodule

// File: tb/tb_ctr_pipe.sv
// tb_ctr_pipe: directed test of ctr_pipe (FP_LAT=3 main instance, FP_LAT=1 side instance).
module tb_ctr_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [3:0] opcode_i, rs_i, rt_i, rd_i;
    logic       branch_taken_i;

    logic        ex_valid_o, r_type_o, stall_o, flush_o, halt_o, fp_busy_o;
    logic [11:0] ex_cv_o;
    logic [3:0]  ex_rd_o;

    logic        ex_valid_1, r_type_1, stall_1, flush_1, halt_1, fp_busy_1;
    logic [11:0] ex_cv_1;
    logic [3:0]  ex_rd_1;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] CV_LW   = 12'b100011001000;
    localparam logic [11:0] CV_ADD  = 12'b100000000000;
    localparam logic [11:0] CV_FP   = 12'b100000000010;

    ctr_pipe #(.FP_LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .branch_taken_i(branch_taken_i),
        .ex_valid_o(ex_valid_o), .ex_cv_o(ex_cv_o), .ex_rd_o(ex_rd_o),
        .r_type_o(r_type_o), .stall_o(stall_o), .flush_o(flush_o),
        .halt_o(halt_o), .fp_busy_o(fp_busy_o)
    );

    ctr_pipe #(.FP_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .branch_taken_i(branch_taken_i),
        .ex_valid_o(ex_valid_1), .ex_cv_o(ex_cv_1), .ex_rd_o(ex_rd_1),
        .r_type_o(r_type_1), .stall_o(stall_1), .flush_o(flush_1),
        .halt_o(halt_1), .fp_busy_o(fp_busy_1)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [3:0] rd, input logic br);
        valid_i = v; opcode_i = op; rs_i = rs; rt_i = rt; rd_i = rd; branch_taken_i = br;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [11:0] exp_cv(input logic [3:0] op);
        case (op)
            4'h0: return 12'b100011001000;
            4'h1: return 12'b000000100000;
            4'h2: return 12'b100000000000;
            4'h3: return 12'b100001000100;
            4'h4: return 12'b101000000000;
            4'h5: return 12'b000100000000;
            4'h7: return 12'b000000000001;
            4'h8: return 12'b100000000010;
            4'h9: return 12'b100000000010;
            4'hA: return 12'b110000000000;
            default: return 12'b000000000000;
        endcase
    endfunction

    int unsigned sweep [16] = '{0, 1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 14, 15, 8, 9, 7};

    initial begin
        logic [3:0] op;
        rst_n = 1'b0;
        // Reset with a branch pending: stall low, flush follows branch.
        drive(1'b1, 4'h2, 4'h1, 4'h2, 4'h3, 1'b1);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_flush_hi", 32'(flush_o), 1);
        tick();
        branch_taken_i = 1'b0;
        #1;
        chk("rst_flush_lo", 32'(flush_o), 0);
        chk("rst_ex_valid", 32'(ex_valid_o), 0);
        chk("rst_ex_cv", 32'(ex_cv_o), 0);
        chk("rst_ex_rd", 32'(ex_rd_o), 0);
        chk("rst_halt", 32'(halt_o), 0);
        chk("rst_fp_busy", 32'(fp_busy_o), 0);
        rst_n = 1'b1;

        // r_type decode spot checks.
        drive(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("rtype_add", 32'(r_type_o), 1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("rtype_lw", 32'(r_type_o), 0);
        drive(1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("rtype_mov", 32'(r_type_o), 0);
        drive(1'b0, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("rtype_slt", 32'(r_type_o), 1);

        // Decode sweep; FP ops hold two cycles, STOP last.
        for (int i = 0; i < 16; i++) begin
            op = 4'(sweep[i]);
            drive(1'b1, op, 4'(op + 4'd8), 4'(op + 4'd8), op, 1'b0);
            chk("sweep_stall", 32'(stall_o), 0);
            tick();
            chk($sformatf("sweep_cv_op%0d", op), 32'(ex_cv_o), 32'(exp_cv(op)));
            chk($sformatf("sweep_valid_op%0d", op), 32'(ex_valid_o), 1);
            chk($sformatf("sweep_rd_op%0d", op), 32'(ex_rd_o), 32'(op));
            if (op == 4'h8 || op == 4'h9) begin
                drive(1'b0, 4'h2, 4'h1, 4'h1, 4'h1, 1'b0);
                chk("fp_busy_c1", 32'(fp_busy_o), 1);
                chk("fp_stall_c1", 32'(stall_o), 1);
                tick();
                chk("fp_bubble_valid", 32'(ex_valid_o), 0);
                chk("fp_bubble_cv", 32'(ex_cv_o), 0);
                chk("fp_busy_c2", 32'(fp_busy_o), 1);
                chk("fp_stall_c2", 32'(stall_o), 1);
                tick();
                chk("fp_busy_done", 32'(fp_busy_o), 0);
                chk("fp_stall_done", 32'(stall_o), 0);
            end
        end

        // Halted: sticky, stalls, flush still follows branch.
        chk("halt_set", 32'(halt_o), 1);
        drive(1'b1, 4'h2, 4'h1, 4'h2, 4'h3, 1'b0);
        chk("halt_stall", 32'(stall_o), 1);
        tick();
        chk("halt_bubble", 32'(ex_valid_o), 0);
        chk("halt_sticky", 32'(halt_o), 1);
        branch_taken_i = 1'b1;
        #1;
        chk("halt_flush", 32'(flush_o), 1);
        tick();
        branch_taken_i = 1'b0;
        #1;
        chk("halt_sticky2", 32'(halt_o), 1);
        chk("halt_stall2", 32'(stall_o), 1);

        // Reset from HALT, then issue resumes.
        rst_n = 1'b0;
        #1;
        chk("rsth_stall", 32'(stall_o), 0);
        tick();
        chk("rsth_halt", 32'(halt_o), 0);
        chk("rsth_valid", 32'(ex_valid_o), 0);
        chk("rsth_cv", 32'(ex_cv_o), 0);
        chk("rsth_rd", 32'(ex_rd_o), 0);
        rst_n = 1'b1;
        drive(1'b1, 4'h2, 4'h1, 4'h2, 4'h5, 1'b0);
        tick();
        chk("rsth_resume_valid", 32'(ex_valid_o), 1);
        chk("rsth_resume_cv", 32'(ex_cv_o), 32'(CV_ADD));

        // valid_i=0 gives a bubble and keeps ex_rd.
        drive(1'b0, 4'h2, 4'h1, 4'h2, 4'h9, 1'b0);
        chk("novalid_stall", 32'(stall_o), 0);
        tick();
        chk("novalid_bubble", 32'(ex_valid_o), 0);
        chk("novalid_rd_hold", 32'(ex_rd_o), 5);

        // Load-use on rs: one stall, one bubble, then the ADD issues.
        drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        tick();
        chk("lu_lw_cv", 32'(ex_cv_o), 32'(CV_LW));
        drive(1'b1, 4'h2, 4'h3, 4'h6, 4'h7, 1'b0);
        chk("lu_stall", 32'(stall_o), 1);
        tick();
        chk("lu_bubble", 32'(ex_valid_o), 0);
        chk("lu_rd_hold", 32'(ex_rd_o), 3);
        chk("lu_stall_clear", 32'(stall_o), 0);
        tick();
        chk("lu_add_valid", 32'(ex_valid_o), 1);
        chk("lu_add_cv", 32'(ex_cv_o), 32'(CV_ADD));
        chk("lu_add_rd", 32'(ex_rd_o), 7);

        // No hazard with unrelated sources.
        drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        tick();
        drive(1'b1, 4'h2, 4'h4, 4'h5, 4'h6, 1'b0);
        chk("nohz_stall", 32'(stall_o), 0);
        // rt matches but LW is not r-type nor SW: no hazard.
        drive(1'b1, 4'h0, 4'h1, 4'h3, 4'h6, 1'b0);
        chk("lw_rt_nohz", 32'(stall_o), 0);
        // rt match with SW is a hazard.
        drive(1'b1, 4'h1, 4'h1, 4'h3, 4'h6, 1'b0);
        chk("sw_rt_hz", 32'(stall_o), 1);

        // Branch overrides the hazard.
        branch_taken_i = 1'b1;
        opcode_i = 4'h2; rs_i = 4'h3;
        #1;
        chk("br_flush", 32'(flush_o), 1);
        chk("br_stall", 32'(stall_o), 0);
        tick();
        chk("br_bubble", 32'(ex_valid_o), 0);
        // Squashed STOP does not halt; squashed MULTF does not occupy the FP unit.
        drive(1'b1, 4'h7, 4'h0, 4'h0, 4'h1, 1'b1);
        tick();
        chk("br_stop_halt", 32'(halt_o), 0);
        chk("br_stop_bubble", 32'(ex_valid_o), 0);
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h1, 1'b1);
        tick();
        chk("br_fp_busy", 32'(fp_busy_o), 0);

        // Branch during FP_WAIT: flush only, countdown unaffected.
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h1, 1'b0);
        tick();
        chk("fpb_cv", 32'(ex_cv_o), 32'(CV_FP));
        drive(1'b1, 4'h2, 4'h4, 4'h5, 4'h6, 1'b1);
        chk("fpb_flush", 32'(flush_o), 1);
        chk("fpb_stall", 32'(stall_o), 0);
        tick();
        chk("fpb_busy_c2", 32'(fp_busy_o), 1);
        branch_taken_i = 1'b0;
        #1;
        chk("fpb_stall_c2", 32'(stall_o), 1);
        tick();
        chk("fpb_busy_done", 32'(fp_busy_o), 0);

        // Reset in mid FP_WAIT, then issue resumes.
        drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h1, 1'b0);
        tick();
        chk("fpr_busy", 32'(fp_busy_o), 1);
        rst_n = 1'b0;
        tick();
        chk("fpr_busy_clr", 32'(fp_busy_o), 0);
        chk("fpr_valid", 32'(ex_valid_o), 0);
        chk("fpr_cv", 32'(ex_cv_o), 0);
        rst_n = 1'b1;
        drive(1'b1, 4'h2, 4'h4, 4'h5, 4'h6, 1'b0);
        chk("fpr_stall", 32'(stall_o), 0);
        tick();
        chk("fpr_resume", 32'(ex_valid_o), 1);

        // FP_LAT=1 instance: no occupancy, no stall.
        do_reset();
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h2, 1'b0);
        tick();
        chk("lat1_cv", 32'(ex_cv_1), 32'(CV_FP));
        chk("lat1_busy", 32'(fp_busy_1), 0);
        drive(1'b1, 4'h2, 4'h4, 4'h5, 4'h6, 1'b0);
        chk("lat1_stall", 32'(stall_1), 0);
        tick();
        chk("lat1_next_valid", 32'(ex_valid_1), 1);
        chk("lat1_next_cv", 32'(ex_cv_1), 32'(CV_ADD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctr_pipe.md
CTR_PIPE -- requirements
Module: ctr_pipe

Interface
REQ-001 Parameters: OP_WIDTH, default 4, opcode width; RA_WIDTH, default 4, register-address width; CV_WIDTH, default 12, control-vector width; FP_LAT, default 3, floating-op occupancy in cycles (legal range 1-15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 valid_i  in  1  decode-stage instruction valid.
REQ-005 opcode_i  in  OP_WIDTH  decode-stage opcode.
REQ-006 rs_i, rt_i, rd_i  in  RA_WIDTH each  decode-stage source and destination register addresses.
REQ-007 branch_taken_i  in  1  EX-stage JMPZ resolved taken.
REQ-008 ex_valid_o  out  1  EX-stage control vector valid.
REQ-009 ex_cv_o  out  CV_WIDTH  registered {RegWrite,ALUop[1:0],Branch,MemRead,RegDst,MemWrite,Jump,MemToReg,Mov,Floating,Stop}.
REQ-010 ex_rd_o  out  RA_WIDTH  registered destination address.
REQ-011 r_type_o  out  1  combinational: decode opcode is ADD, SUB, MULTF, NOP, STOP, JMPZ or SLT.
REQ-012 stall_o  out  1  hold IF/ID this cycle.
REQ-013 flush_o  out  1  squash IF/ID this cycle.
REQ-014 halt_o  out  1  processor halted; sticky.
REQ-015 fp_busy_o  out  1  floating unit occupied.

Function
REQ-016 Decode table SHALL be: LW 0000->100011001000, SW 0001->000000100000, ADD 0010->100000000000, MOV 0011->100001000100, SUB 0100->101000000000, JMPZ 0101->000100000000, STOP 0111->000000000001, ADDF 1000->100000000010, MULTF 1001->100000000010, SLT 1010->110000000000, NOP 1111 and every other opcode->all zeros.
REQ-017 FSM states SHALL be RUN, FP_WAIT, HALT; reset state RUN.
REQ-018 Issue SHALL occur in RUN when valid_i=1, branch_taken_i=0 and no load-use hazard; on issue ex_cv_o, ex_rd_o and ex_valid_o=1 are loaded at the next edge (latency 1 cycle).
REQ-019 In any non-issue cycle ex_cv_o SHALL load zero and ex_valid_o SHALL load 0 (bubble); ex_rd_o SHALL hold its value.
REQ-020 Load-use hazard SHALL be ex_valid_o=1 AND ex_cv_o MemRead=1 AND (ex_rd_o==rs_i OR (ex_rd_o==rt_i AND (r_type_o=1 OR opcode SW))) with valid_i=1; stall_o=1 combinationally for that cycle, one bubble inserted.
REQ-021 flush_o SHALL equal branch_taken_i combinationally; branch_taken_i SHALL override hazard stall, FP issue and STOP issue of the squashed instruction (stall_o=0, no state change, bubble).
REQ-022 Issue of ADDF or MULTF SHALL load a down-counter with FP_LAT-1 and enter FP_WAIT if FP_LAT>1; for FP_LAT=1 remain in RUN.
REQ-023 In FP_WAIT: fp_busy_o=1, stall_o=1 (unless branch_taken_i=1), bubbles inserted, counter decrements each cycle; at counter==1 return to RUN next edge, so exactly FP_LAT-1 stall cycles follow an FP issue.
REQ-024 branch_taken_i during FP_WAIT SHALL assert flush_o only; counter and state continue unaffected.
REQ-025 Issue of STOP SHALL enter HALT; in HALT halt_o=1, stall_o=1, bubbles inserted, flush_o still follows branch_taken_i; exit only by reset.
REQ-026 valid_i=0 in RUN SHALL produce a bubble with stall_o=0.
REQ-027 stall_o, flush_o, r_type_o SHALL be combinational; all other outputs registered.

Reset
REQ-028 rst_n=0 at an edge SHALL set state RUN, counter 0, ex_valid_o=0, ex_cv_o=0, ex_rd_o=0, halt_o=0, fp_busy_o=0, overriding any in-progress FP_WAIT or HALT.
REQ-029 While rst_n=0, stall_o=0 and flush_o SHALL still follow branch_taken_i.

Verification
REQ-030 Decode sweep: each of 16 opcodes, valid_i=1 -> next cycle ex_cv_o per REQ-016 (0110, 1011-1110 give 0), ex_valid_o=1 except in bubbles.
REQ-031 Load-use: LW rd=3 issued, then ADD rs=3 -> stall_o=1 one cycle, one bubble, ADD issued next cycle; ADD rs=4 rt=5 -> no stall.
REQ-032 FP: FP_LAT=3, MULTF issued -> fp_busy_o=1 and stall_o=1 for exactly 2 cycles, then RUN; FP_LAT=1 -> no stall.
REQ-033 Branch priority: branch_taken_i=1 with hazard present -> flush_o=1, stall_o=0, bubble; with STOP in decode -> halt_o stays 0.
REQ-034 Halt and reset: STOP issued -> halt_o=1 next cycle, stall_o=1 indefinitely; rst_n=0 for one edge mid-FP_WAIT or in HALT -> all outputs per REQ-028, issue resumes next cycle.
